// File: rtl/time_count_decoder.sv
// time_count_decoder
// Serial converter from a 64-bit centisecond count since 1970-01-01 00:00:00.00 UTC
// to calendar display fields. One restoring divider is shared across the
// division phases. Year and month are found by repeated subtraction.
//
// Optional feature macro: WEEKDAY_EN
//   defined   -> MOD7 phase present, dayDisplay carries the weekday (0=Sun).
//   undefined -> MOD7 skipped (64 cycles shorter), dayDisplay tied to 0.
//
// Ports:
//   clockSignal          in   clock, rising edge
//   reset                in   synchronous, active-high
//   start                in   conversion request, honoured only while busy=0
//   countIn[63:0]        in   centiseconds since epoch, latched on accepted start
//   busy                 out  conversion in progress (still 1 in the done cycle)
//   done                 out  one-cycle pulse, displays valid in this cycle
//   overflow             out  last request exceeded YEAR_MAX
//   yearDisplay[13:0], monthDisplay[3:0], dateDisplay[4:0], dayDisplay[2:0]
//   timeInHoursDisplay[4:0], timeInMinutesDisplay[5:0],
//   secondsDisplay[5:0], centisecondsDisplay[6:0]
module time_count_decoder #(
  parameter int unsigned YEAR_MAX = 16383
) (
  input  logic        clockSignal,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] countIn,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [13:0] yearDisplay,
  output logic [3:0]  monthDisplay,
  output logic [4:0]  dateDisplay,
  output logic [2:0]  dayDisplay,
  output logic [4:0]  timeInHoursDisplay,
  output logic [5:0]  timeInMinutesDisplay,
  output logic [5:0]  secondsDisplay,
  output logic [6:0]  centisecondsDisplay
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DIV100   = 4'd1;
  localparam logic [3:0] DIV86400 = 4'd2;
  localparam logic [3:0] MOD7     = 4'd3;
  localparam logic [3:0] DIV3600  = 4'd4;
  localparam logic [3:0] DIV60    = 4'd5;
  localparam logic [3:0] YEAR     = 4'd6;
  localparam logic [3:0] MONTH    = 4'd7;
  localparam logic [3:0] FINISH   = 4'd8;

  localparam logic [13:0] YEAR_LAST = 14'(YEAR_MAX);

  logic [3:0]  state;
  logic [63:0] num;       // dividend shifting out, quotient shifting in
  logic [16:0] rem;
  logic [6:0]  cnt;
  logic [63:0] days;
  logic        ovf_pend;
  logic [6:0]  st_cs;
  logic [4:0]  st_h;
  logic [5:0]  st_m;
  logic [5:0]  st_s;
  logic [13:0] st_year;
  logic [3:0]  st_month;
  logic [4:0]  st_date;
`ifdef WEEKDAY_EN
  logic [16:0] sod;
  logic [2:0]  st_wday;
`endif

  logic [16:0] divisor;
  logic [6:0]  iter_last;
  logic [17:0] rem_sh;
  logic [17:0] rem_sub;
  logic        ge;
  logic [16:0] rem_next;
  logic [63:0] num_next;
  logic        last_iter;
  logic        leap;
  logic [63:0] year_len;
  logic [63:0] month_len;

  function automatic logic is_leap(input logic [13:0] y);
    return (y[1:0] == 2'b00) && (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
  endfunction

  function automatic logic [4:0] month_days(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      return lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  always_comb begin
    divisor   = 17'd1;
    iter_last = 7'd0;
    case (state)
      DIV100:   begin divisor = 17'd100;   iter_last = 7'd63; end
      DIV86400: begin divisor = 17'd86400; iter_last = 7'd63; end
`ifdef WEEKDAY_EN
      MOD7:     begin divisor = 17'd7;     iter_last = 7'd63; end
`endif
      DIV3600:  begin divisor = 17'd3600;  iter_last = 7'd16; end
      DIV60:    begin divisor = 17'd60;    iter_last = 7'd11; end
      default:  begin divisor = 17'd1;     iter_last = 7'd0;  end
    endcase
    rem_sh    = {rem, num[63]};
    rem_sub   = rem_sh - {1'b0, divisor};
    ge        = rem_sh >= {1'b0, divisor};
    rem_next  = ge ? 17'(rem_sub) : 17'(rem_sh);
    num_next  = {num[62:0], ge};
    last_iter = (cnt == iter_last);
    leap      = is_leap(st_year);
    year_len  = leap ? 64'd366 : 64'd365;
    month_len = 64'(month_days(st_month, leap));
  end

`ifndef WEEKDAY_EN
  assign dayDisplay = '0;
`endif

  always_ff @(posedge clockSignal) begin
    if (reset) begin
      state                <= IDLE;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      overflow             <= 1'b0;
      yearDisplay          <= 14'd1970;
      monthDisplay         <= 4'd1;
      dateDisplay          <= 5'd1;
`ifdef WEEKDAY_EN
      dayDisplay           <= 3'd4;
`endif
      timeInHoursDisplay   <= '0;
      timeInMinutesDisplay <= '0;
      secondsDisplay       <= '0;
      centisecondsDisplay  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high for the cycle that carries done, so a start
          // coinciding with done is dropped here.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy     <= 1'b1;
            num      <= countIn;
            rem      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            state    <= DIV100;
          end
        end
        DIV100, DIV86400, MOD7, DIV3600, DIV60: begin
          num <= num_next;
          rem <= rem_next;
          cnt <= cnt + 7'd1;
          if (last_iter) begin
            cnt <= '0;
            rem <= '0;
            case (state)
              DIV100: begin
                st_cs <= 7'(rem_next);
                state <= DIV86400;
              end
              DIV86400: begin
                days <= num_next;
`ifdef WEEKDAY_EN
                sod   <= rem_next;
                num   <= num_next + 64'd4;
                state <= MOD7;
`else
                num   <= {rem_next, 47'd0};
                state <= DIV3600;
`endif
              end
`ifdef WEEKDAY_EN
              MOD7: begin
                st_wday <= 3'(rem_next);
                num     <= {sod, 47'd0};
                state   <= DIV3600;
              end
`endif
              DIV3600: begin
                // The 17-/12-bit operands sit at the top of num so the
                // short divides only need that many iterations.
                st_h  <= 5'(num_next);
                num   <= {12'(rem_next), 52'd0};
                state <= DIV60;
              end
              default: begin
                st_m    <= 6'(num_next);
                st_s    <= 6'(rem_next);
                st_year <= 14'd1970;
                state   <= YEAR;
              end
            endcase
          end
        end
        YEAR: begin
          if (days >= year_len) begin
            if (st_year == YEAR_LAST) begin
              ovf_pend <= 1'b1;
              state    <= FINISH;
            end else begin
              days    <= days - year_len;
              st_year <= st_year + 14'd1;
            end
          end else begin
            st_month <= 4'd1;
            state    <= MONTH;
          end
        end
        MONTH: begin
          if (days >= month_len) begin
            days     <= days - month_len;
            st_month <= st_month + 4'd1;
          end else begin
            st_date <= 5'(days) + 5'd1;
            state   <= FINISH;
          end
        end
        FINISH: begin
          done     <= 1'b1;
          overflow <= ovf_pend;
          state    <= IDLE;
          if (!ovf_pend) begin
            yearDisplay          <= st_year;
            monthDisplay         <= st_month;
            dateDisplay          <= st_date;
`ifdef WEEKDAY_EN
            dayDisplay           <= st_wday;
`endif
            timeInHoursDisplay   <= st_h;
            timeInMinutesDisplay <= st_m;
            secondsDisplay       <= st_s;
            centisecondsDisplay  <= st_cs;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_count_decoder.sv
// Testbench for time_count_decoder: directed calendar cases plus random counts,
// compared against a calendar model built on days-from-civil arithmetic.
module tb_time_count_decoder;

  localparam longint YMAX = 16383;
`ifdef WEEKDAY_EN
  localparam bit WEEKDAY = 1'b1;
`else
  localparam bit WEEKDAY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] count_in;
  logic        busy, done, overflow;
  logic [13:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  date_d;
  logic [2:0]  day_d;
  logic [4:0]  hours_d;
  logic [5:0]  minutes_d;
  logic [5:0]  seconds_d;
  logic [6:0]  cs_d;

  time_count_decoder #(.YEAR_MAX(16383)) dut (
    .clockSignal(clk), .reset(reset), .start(start), .countIn(count_in),
    .busy(busy), .done(done), .overflow(overflow),
    .yearDisplay(year_d), .monthDisplay(month_d), .dateDisplay(date_d),
    .dayDisplay(day_d), .timeInHoursDisplay(hours_d),
    .timeInMinutesDisplay(minutes_d), .secondsDisplay(seconds_d),
    .centisecondsDisplay(cs_d)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // expected display contents
  longint e_year, e_month, e_date, e_wday, e_h, e_m, e_s, e_cs;
  longint e_ovf;
  // model result of the most recent request
  longint m_year, m_month, m_date, m_wday, m_h, m_m, m_s, m_cs;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint days_from_civil(input longint y_in, input longint m, input longint d);
    longint y, era, yoe, doy, doe;
    y   = (m <= 2) ? y_in - 1 : y_in;
    era = y / 400;
    yoe = y - era * 400;
    doy = (153 * ((m > 2) ? m - 3 : m + 9) + 2) / 5 + d - 1;
    doe = yoe * 365 + yoe / 4 - yoe / 100 + doy;
    return era * 146097 + doe - 719468;
  endfunction

  task automatic civil_from_days(input longint z_in, output longint y, output longint m, output longint d);
    longint z, era, doe, yoe, doy, mp;
    z   = z_in + 719468;
    era = z / 146097;
    doe = z - era * 146097;
    yoe = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
    y   = yoe + era * 400;
    doy = doe - (365 * yoe + yoe / 4 - yoe / 100);
    mp  = (5 * doy + 2) / 153;
    d   = doy - (153 * mp + 2) / 5 + 1;
    m   = (mp < 10) ? mp + 3 : mp - 9;
    if (m <= 2) y++;
  endtask

  task automatic model(input logic [63:0] c, output bit ovf, output longint lat);
    longint unsigned secs, dys;
    longint y, mo, d;
    m_cs   = longint'(c % 64'd100);
    secs   = c / 64'd100;
    m_s    = longint'(secs % 60);
    m_m    = longint'((secs / 60) % 60);
    m_h    = longint'((secs / 3600) % 24);
    dys    = secs / 86400;
    m_wday = longint'((dys + 4) % 7);
    civil_from_days(longint'(dys), y, mo, d);
    m_year = y; m_month = mo; m_date = d;
    ovf = (y > YMAX);
    // accept + DIV100 + [MOD7] + DIV86400 + DIV3600 + DIV60 + YEAR + MONTH + FINISH
    lat = 1 + 64 + (WEEKDAY ? 64 : 0) + 64 + 17 + 12 + 1;
    lat += ovf ? (YMAX - 1970 + 1) : ((y - 1970 + 1) + mo);
  endtask

  task automatic apply_expect(input bit ovf);
    if (ovf) begin
      e_ovf = 1;
    end else begin
      e_ovf = 0;
      e_year = m_year; e_month = m_month; e_date = m_date; e_wday = m_wday;
      e_h = m_h; e_m = m_m; e_s = m_s; e_cs = m_cs;
    end
  endtask

  task automatic set_reset_expect();
    e_year = 1970; e_month = 1; e_date = 1; e_wday = 4;
    e_h = 0; e_m = 0; e_s = 0; e_cs = 0; e_ovf = 0;
  endtask

  task automatic check_displays(input string ctx);
    check({ctx, ".year"},  longint'(year_d),    e_year);
    check({ctx, ".month"}, longint'(month_d),   e_month);
    check({ctx, ".date"},  longint'(date_d),    e_date);
    check({ctx, ".day"},   longint'(day_d),     WEEKDAY ? e_wday : 0);
    check({ctx, ".hour"},  longint'(hours_d),   e_h);
    check({ctx, ".min"},   longint'(minutes_d), e_m);
    check({ctx, ".sec"},   longint'(seconds_d), e_s);
    check({ctx, ".cs"},    longint'(cs_d),      e_cs);
    check({ctx, ".ovf"},   longint'(overflow),  e_ovf);
  endtask

  task automatic run_conv(input logic [63:0] c, input string ctx);
    bit ovf, seen;
    longint lat, n;
    model(c, ovf, lat);
    @(negedge clk);
    start = 1'b1; count_in = c;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; seen = 1'b0;
    while (n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (done) begin seen = 1'b1; break; end
    end
    check({ctx, ".done_seen"}, longint'(seen), 1);
    check({ctx, ".latency"}, n, lat);
    check({ctx, ".busy_in_done"}, longint'(busy), 1);
    apply_expect(ovf);
    check_displays(ctx);
    @(posedge clk); #1;
    check({ctx, ".done_pulse"}, longint'(done), 0);
    check({ctx, ".busy_after"}, longint'(busy), 0);
  endtask

  initial begin
    bit ovf;
    longint lat, n, dones;
    logic [63:0] c, hs_a, hs_b;

    reset = 1'b1; start = 1'b0; count_in = '0;
    repeat (3) @(posedge clk);
    #1;
    set_reset_expect();
    check("reset.busy", longint'(busy), 0);
    check("reset.done", longint'(done), 0);
    check_displays("reset");
    @(negedge clk);
    reset = 1'b0;

    run_conv(64'd0, "epoch");
    run_conv(64'd95182769678, "leapday");
    check("leapday.year_const", longint'(year_d), 2000);
    check("leapday.date_const", longint'(date_d), 29);
    run_conv(64'd9469439999, "rollover_a");
    run_conv(64'd9469440000, "rollover_b");

    run_conv(64'd0, "ovf_pre");
    run_conv(64'hFFFF_FFFF_FFFF_FFFF, "ovf_max");
    check("ovf_max.flag", longint'(overflow), 1);
    run_conv(64'd0, "ovf_clear");

    // two extra start pulses while busy: neither is queued
    hs_a = 64'd123456789012;
    hs_b = 64'd95182769678;
    model(hs_a, ovf, lat);
    @(negedge clk);
    start = 1'b1; count_in = hs_a;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 1; i < 1500; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start    = (i == 10 || i == 60);
      count_in = start ? hs_b : hs_a;
    end
    start = 1'b0;
    check("hs.done_count", dones, 1);
    apply_expect(ovf);
    check_displays("hs");

    // start raised in the done cycle is ignored
    model(64'd0, ovf, lat);
    @(negedge clk);
    start = 1'b1; count_in = 64'd0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 20000 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    check("dcs.latency", n, lat);
    start = 1'b1; count_in = 64'd95182769678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dcs.busy", longint'(busy), 0);
    apply_expect(ovf);
    check_displays("dcs");

    for (int k = 0; k < 12; k++) begin
      c = {32'($urandom), 32'($urandom)} % 64'd410000000000;
      run_conv(c, $sformatf("rand%0d", k));
    end

    c = 64'(days_from_civil(YMAX + 1, 1, 1)) * 64'd8640000;
    run_conv(c - 64'd1, "last_valid");
    run_conv(c, "first_ovf");

    // reset part-way through a conversion
    @(negedge clk);
    start = 1'b1; count_in = 64'd95182769678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_reset_expect();
    check("midreset.busy", longint'(busy), 0);
    check("midreset.done", longint'(done), 0);
    check_displays("midreset");
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midreset.no_done", dones, 0);
    check("midreset.idle", longint'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
